// File: rtl/ogfx_sync_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ogfx_sync_rx_ctrl_if
//  Description : Bundle of the toggle-handshake receive signals. The master
//                side is the source/consumer pair; the slave side is the
//                receive controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ogfx_sync_rx_ctrl_if #(
  parameter int DW = 16
);
  logic          req_tgl_sync;
  logic [DW-1:0] xfer_data;
  logic          ack_tgl;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy;
  logic          err;

  modport master (
    output req_tgl_sync, xfer_data, rx_ready,
    input  ack_tgl, rx_data, rx_valid, busy, err
  );

  modport slave (
    input  req_tgl_sync, xfer_data, rx_ready,
    output ack_tgl, rx_data, rx_valid, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/ogfx_sync_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ogfx_sync_rx_ctrl
//  Description : Receive side of the toggle-handshake clock-domain crossing.
//                Detects an edge on the synchronized request toggle, waits
//                SETTLE cycles, captures the quasi-static data bus, offers it
//                with valid/ready and returns an acknowledge toggle once the
//                word is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module ogfx_sync_rx_ctrl #(
  parameter int DW     = 16,
  parameter int SETTLE = 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ogfx_sync_rx_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  // Counter preload; SETTLE=0 never enters ST_SETTLE so the value is unused.
  localparam logic [2:0] c_settle_load = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic          r_req_d;
  logic          r_ack;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_err;
  logic          w_edge;

  // A change of the request toggle marks a new word from the source domain.
  assign w_edge = bus.req_tgl_sync ^ r_req_d;

  // Transfer sequencing: settle, capture, hold until accepted, acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_req_d <= 1'b0;
      r_ack   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_req_d <= bus.req_tgl_sync;
      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            if (SETTLE == 0) begin
              r_data  <= bus.xfer_data;
              r_valid <= 1'b1;
              r_state <= ST_OUT;
            end else begin
              r_cnt   <= c_settle_load;
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          // A new edge before this word is acknowledged breaks the protocol;
          // it is flagged and dropped, the transfer in flight is unaffected.
          if (w_edge) begin
            r_err <= 1'b1;
          end
          if (r_cnt == 3'd0) begin
            r_data  <= bus.xfer_data;
            r_valid <= 1'b1;
            r_state <= ST_OUT;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_OUT: begin
          if (w_edge) begin
            r_err <= 1'b1;
          end
          if (bus.rx_ready) begin
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_tgl  = r_ack;
  assign bus.rx_data  = r_data;
  assign bus.rx_valid = r_valid;
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ogfx_sync_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ogfx_sync_rx_ctrl
//  Description : Bench for ogfx_sync_rx_ctrl. Two instances (SETTLE=0 and
//                SETTLE=3) share one source/consumer stimulus; a timestamp
//                model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ogfx_sync_rx_ctrl;
  localparam int DW = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          req   = 1'b0;
  logic [DW-1:0] xdata = '0;
  logic          ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ogfx_sync_rx_ctrl_if #(.DW(DW)) if0 ();
  ogfx_sync_rx_ctrl_if #(.DW(DW)) if3 ();

  assign if0.req_tgl_sync = req;
  assign if0.xfer_data    = xdata;
  assign if0.rx_ready     = ready;
  assign if3.req_tgl_sync = req;
  assign if3.xfer_data    = xdata;
  assign if3.rx_ready     = ready;

  ogfx_sync_rx_ctrl #(.DW(DW), .SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  ogfx_sync_rx_ctrl #(.DW(DW), .SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  // Source-side two-flop synchronizers of the returned acknowledges.
  logic a0_m, a0_s, a3_m, a3_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_m <= 1'b0; a0_s <= 1'b0; a3_m <= 1'b0; a3_s <= 1'b0;
    end else begin
      a0_m <= if0.ack_tgl; a0_s <= a0_m;
      a3_m <= if3.ack_tgl; a3_s <= a3_m;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Index 0 models SETTLE=0, index 1 models SETTLE=3. A transfer is
  // described by the cycle at which its word is captured.
  int            cyc;
  bit            m_busy [2];
  bit            m_valid[2];
  bit            m_ack  [2];
  bit            m_err  [2];
  bit            m_req_d[2];
  logic [DW-1:0] m_data [2];
  int            m_cap  [2];

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_busy[d] = 0; m_valid[d] = 0; m_ack[d] = 0; m_err[d] = 0;
          m_req_d[d] = 0; m_data[d] = '0; m_cap[d] = 0;
        end else begin
          bit edge_now, was_busy;
          edge_now = req ^ m_req_d[d];
          was_busy = m_busy[d];
          if (m_valid[d] && ready) begin
            m_valid[d] = 0; m_ack[d] = ~m_ack[d]; m_busy[d] = 0;
          end
          if (edge_now) begin
            if (was_busy) m_err[d] = 1;
            else begin
              m_busy[d] = 1;
              m_cap[d]  = cyc + ((d == 0) ? 0 : 3);
            end
          end
          if (m_busy[d] && !m_valid[d] && cyc == m_cap[d]) begin
            m_valid[d] = 1; m_data[d] = xdata;
          end
          m_req_d[d] = req;
        end
      end
      if (!rst) cyc++;
    end
  end

  task automatic cmp_dut(input int d, input logic ack, input logic valid,
                         input logic [DW-1:0] data, input logic busy, input logic err);
    chk($sformatf("cyc.d%0d.ack", d),   ack,   m_ack[d]);
    chk($sformatf("cyc.d%0d.valid", d), valid, m_valid[d]);
    chk($sformatf("cyc.d%0d.data", d),  data,  m_data[d]);
    chk($sformatf("cyc.d%0d.busy", d),  busy,  m_busy[d]);
    chk($sformatf("cyc.d%0d.err", d),   err,   m_err[d]);
  endtask

  // Per-cycle compare, plus handshake log and ack-flip counters.
  logic [DW-1:0] recv0[$], recv3[$], sent[$];
  int            flips0 = 0, flips3 = 0;
  logic          p0 = 1'b0, p3 = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      cmp_dut(0, if0.ack_tgl, if0.rx_valid, if0.rx_data, if0.busy, if0.err);
      cmp_dut(1, if3.ack_tgl, if3.rx_valid, if3.rx_data, if3.busy, if3.err);
      if (!rst) begin
        if (if0.ack_tgl != p0) flips0++;
        if (if3.ack_tgl != p3) flips3++;
        if (if0.rx_valid && ready) recv0.push_back(if0.rx_data);
        if (if3.rx_valid && ready) recv3.push_back(if3.rx_data);
      end
      p0 = if0.ack_tgl;
      p3 = if3.ack_tgl;
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_toggle(input logic [DW-1:0] w);
    xdata = w;
    req   = ~req;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1; req = 1'b0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_stream(input string tag);
    int  b0, b3, f0, f3;
    bit  done;
    logic [DW-1:0] w;
    b0 = recv0.size(); b3 = recv3.size(); f0 = flips0; f3 = flips3;
    sent.delete();
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      sent.push_back(w);
      send_toggle(w);
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
        ready = 1'($urandom_range(0, 1));
        tick();
        if (a0_s == req && a3_s == req) done = 1;
      end
      chk($sformatf("%s.ack_wait%0d", tag, i), done, 1);
    end
    ready = 1'b1;
    repeat (4) tick();
    chk({tag, ".count0"}, recv0.size() - b0, 8);
    chk({tag, ".count3"}, recv3.size() - b3, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.word0_%0d", tag, i), recv0[b0 + i], sent[i]);
      chk($sformatf("%s.word3_%0d", tag, i), recv3[b3 + i], sent[i]);
    end
    chk({tag, ".flips0"}, flips0 - f0, 8);
    chk({tag, ".flips3"}, flips3 - f3, 8);
    chk({tag, ".err0"}, if0.err, 0);
    chk({tag, ".err3"}, if3.err, 0);
  endtask

  initial begin
    // Reset values.
    #1 rst = 1'b1;
    #1;
    chk("rst.ack", if3.ack_tgl, 0);
    chk("rst.valid", if3.rx_valid, 0);
    chk("rst.data", if3.rx_data, 0);
    chk("rst.busy", if3.busy, 0);
    chk("rst.err", if3.err, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Latency, SETTLE=0 and SETTLE=3.
    ready = 1'b1;
    send_toggle(16'hA5C3);                     // cycle T
    tick();                                    // T+1
    chk("lat.s0.valid_T1", if0.rx_valid, 1);
    chk("lat.s0.data_T1", if0.rx_data, 16'hA5C3);
    chk("lat.s3.busy_T1", if3.busy, 1);
    tick();                                    // T+2
    chk("lat.s0.ack_T2", if0.ack_tgl, 1);
    chk("lat.s0.valid_T2", if0.rx_valid, 0);
    tick();                                    // T+3
    chk("lat.s3.valid_T3", if3.rx_valid, 0);
    chk("lat.s3.busy_T3", if3.busy, 1);
    tick();                                    // T+4
    chk("lat.s3.valid_T4", if3.rx_valid, 1);
    chk("lat.s3.data_T4", if3.rx_data, 16'hA5C3);
    chk("lat.s3.ack_T4", if3.ack_tgl, 0);
    tick();                                    // T+5
    chk("lat.s3.ack_T5", if3.ack_tgl, 1);
    chk("lat.s3.valid_T5", if3.rx_valid, 0);
    chk("lat.s3.busy_T5", if3.busy, 0);
    repeat (3) tick();

    // Backpressure.
    ready = 1'b0;
    send_toggle(16'h1234);
    repeat (4) tick();
    repeat (10) tick();
    chk("bp.s3.valid_hold", if3.rx_valid, 1);
    chk("bp.s3.data_hold", if3.rx_data, 16'h1234);
    chk("bp.s3.ack_hold", if3.ack_tgl, 1);
    chk("bp.s0.valid_hold", if0.rx_valid, 1);
    chk("bp.s0.ack_hold", if0.ack_tgl, 1);
    ready = 1'b1;
    tick();
    chk("bp.s3.ack_flip", if3.ack_tgl, 0);
    chk("bp.s3.valid_drop", if3.rx_valid, 0);
    chk("bp.s0.ack_flip", if0.ack_tgl, 0);
    repeat (3) tick();

    // Protocol violation: second toggle while the word is still in OUT.
    ready = 1'b0;
    send_toggle(16'h0BAD);
    repeat (4) tick();
    chk("viol.s3.err_before", if3.err, 0);
    tick();
    req = ~req;
    tick(); tick();
    chk("viol.s3.err", if3.err, 1);
    chk("viol.s0.err", if0.err, 1);
    chk("viol.s3.data", if3.rx_data, 16'h0BAD);
    chk("viol.s3.ack_none", if3.ack_tgl, 0);
    ready = 1'b1;
    tick();
    chk("viol.s3.ack_once", if3.ack_tgl, 1);
    chk("viol.s0.ack_once", if0.ack_tgl, 1);
    repeat (6) tick();
    chk("viol.s3.ack_no_extra", if3.ack_tgl, 1);
    chk("viol.s3.valid_no_extra", if3.rx_valid, 0);
    chk("viol.s3.err_sticky", if3.err, 1);
    chk("viol.s3.busy", if3.busy, 0);

    // Streams with random consumer backpressure.
    do_reset();
    run_stream("strm1");

    // Reset while the SETTLE=3 instance is settling.
    ready = 1'b0;
    send_toggle(16'h5A5A);
    tick();                                    // T+1, instance 3 in SETTLE
    chk("rstset.s3.busy_pre", if3.busy, 1);
    #1;
    rst = 1'b1; req = 1'b0;
    #1;
    chk("rstset.s3.busy", if3.busy, 0);
    chk("rstset.s3.ack", if3.ack_tgl, 0);
    chk("rstset.s3.valid", if3.rx_valid, 0);
    chk("rstset.s0.valid", if0.rx_valid, 0);
    chk("rstset.s0.data", if0.rx_data, 0);
    tick(); tick();
    rst = 1'b0;
    ready = 1'b1;
    repeat (6) tick();
    chk("rstset.s3.ack_after", if3.ack_tgl, 0);
    chk("rstset.s3.valid_after", if3.rx_valid, 0);
    run_stream("strm2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
